// File: rtl/fb_sram_responder.sv
// Frame-buffer SRAM responder: one async-SRAM access per Read/Write request, with WAIT_CYCLES wait states.
// Optional FB_SRAM_ACCESS_COUNT_EN adds completed-access counters Rd_Count / Wr_Count.
module fb_sram_responder #(
  parameter int MAX_ADDRESS = 307200,
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [19:0]       R_Address,
  input  logic [19:0]       W_Address,
  input  logic [DATA_W-1:0] W_Data,
  output logic              Busy,
  output logic [DATA_W-1:0] R_Data,
  output logic              R_Valid,
  output logic              W_Done,
  output logic              Err,
  output logic              Overrun,
`ifdef FB_SRAM_ACCESS_COUNT_EN
  output logic [31:0]       Rd_Count,
  output logic [31:0]       Wr_Count,
`endif
  output logic [19:0]       SRAM_Addr,
  output logic [DATA_W-1:0] SRAM_DQ_Out,
  input  logic [DATA_W-1:0] SRAM_DQ_In,
  output logic              SRAM_DQ_OE,
  output logic              SRAM_CE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N
);
  localparam int AW = 20;
  localparam logic [AW:0] MAX_A = (AW+1)'(MAX_ADDRESS);

  typedef enum logic [2:0] {IDLE, RD_SETUP, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
  typedef struct packed {
    logic              vld;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t            state;
  req_t              rd_pend, wr_pend;
  logic [3:0]        wcnt;

  logic              acc_vld, acc_wr, in_range;
  logic [AW-1:0]     acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              take_rd_pend, take_wr_pend, take_live_rd, take_live_wr;
  logic              rd_free, wr_free;

  // Source select in IDLE: pending read, pending write, live Read, live Write.
  always_comb begin
    acc_vld      = 1'b0;
    acc_wr       = 1'b0;
    acc_addr     = '0;
    acc_data     = '0;
    take_rd_pend = 1'b0;
    take_wr_pend = 1'b0;
    take_live_rd = 1'b0;
    take_live_wr = 1'b0;
    if (state == IDLE) begin
      if (rd_pend.vld) begin
        acc_vld = 1'b1; acc_addr = rd_pend.addr; acc_data = rd_pend.data; take_rd_pend = 1'b1;
      end else if (wr_pend.vld) begin
        acc_vld = 1'b1; acc_wr = 1'b1; acc_addr = wr_pend.addr; acc_data = wr_pend.data;
        take_wr_pend = 1'b1;
      end else if (Read) begin
        acc_vld = 1'b1; acc_addr = R_Address; take_live_rd = 1'b1;
      end else if (Write) begin
        acc_vld = 1'b1; acc_wr = 1'b1; acc_addr = W_Address; acc_data = W_Data;
        take_live_wr = 1'b1;
      end
    end
  end

  assign in_range = {1'b0, acc_addr} < MAX_A;
  // A slot being consumed this edge can take a new live request of its direction.
  assign rd_free  = !rd_pend.vld || take_rd_pend;
  assign wr_free  = !wr_pend.vld || take_wr_pend;
  assign Busy     = (state != IDLE) || rd_pend.vld || wr_pend.vld;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      rd_pend     <= '0;
      wr_pend     <= '0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_DQ_OE  <= 1'b0;
      SRAM_Addr   <= '0;
      SRAM_DQ_Out <= '0;
      R_Data      <= '0;
      R_Valid     <= 1'b0;
      W_Done      <= 1'b0;
      Err         <= 1'b0;
      Overrun     <= 1'b0;
    end else begin
      R_Valid <= 1'b0;
      W_Done  <= 1'b0;
      Err     <= 1'b0;

      if (take_rd_pend) rd_pend.vld <= 1'b0;
      if (take_wr_pend) wr_pend.vld <= 1'b0;
      if (Read && !take_live_rd) begin
        if (rd_free) rd_pend <= '{1'b1, R_Address, {DATA_W{1'b0}}};
        else         Overrun <= 1'b1;
      end
      if (Write && !take_live_wr) begin
        if (wr_free) wr_pend <= '{1'b1, W_Address, W_Data};
        else         Overrun <= 1'b1;
      end

      case (state)
        IDLE: if (acc_vld) begin
          if (!in_range) begin
            Err <= 1'b1;
          end else if (acc_wr) begin
            state       <= WR_SETUP;
            SRAM_Addr   <= acc_addr;
            SRAM_DQ_Out <= acc_data;
            SRAM_DQ_OE  <= 1'b1;
            SRAM_CE_N   <= 1'b0;
            SRAM_WE_N   <= 1'b1;
          end else begin
            state      <= RD_SETUP;
            SRAM_Addr  <= acc_addr;
            SRAM_DQ_OE <= 1'b0;
            SRAM_CE_N  <= 1'b0;
            SRAM_OE_N  <= 1'b0;
          end
        end
        RD_SETUP: begin
          state <= RD_WAIT;
          wcnt  <= 4'(WAIT_CYCLES - 1);
        end
        RD_WAIT: begin
          if (wcnt == '0) begin
            R_Data    <= SRAM_DQ_In;
            R_Valid   <= 1'b1;
            SRAM_CE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            state     <= IDLE;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          SRAM_WE_N <= 1'b0;
          wcnt      <= 4'(WAIT_CYCLES - 1);
        end
        WR_PULSE: begin
          if (wcnt == '0) begin
            SRAM_WE_N <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        WR_HOLD: begin
          W_Done     <= 1'b1;
          SRAM_CE_N  <= 1'b1;
          SRAM_DQ_OE <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FB_SRAM_ACCESS_COUNT_EN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Rd_Count <= '0;
      Wr_Count <= '0;
    end else begin
      if (R_Valid) Rd_Count <= Rd_Count + 32'd1;
      if (W_Done)  Wr_Count <= Wr_Count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_sram_responder.sv
// Directed-vector bench for fb_sram_responder: stimulus pushes expected strobes, a negedge monitor pops and checks them.
module tb_fb_sram_responder;
  localparam int WC = 2;

  logic        Clk = 1'b0, Reset = 1'b1, Read = 1'b0, Write = 1'b0;
  logic [19:0] R_Address = '0, W_Address = '0;
  logic [15:0] W_Data = '0;
  logic        Busy, R_Valid, W_Done, Err, Overrun;
  logic [15:0] R_Data, SRAM_DQ_Out, SRAM_DQ_In;
  logic [19:0] SRAM_Addr;
  logic        SRAM_DQ_OE, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
`ifdef FB_SRAM_ACCESS_COUNT_EN
  logic [31:0] Rd_Count, Wr_Count;
`endif

  fb_sram_responder #(.MAX_ADDRESS(307200), .WAIT_CYCLES(WC), .DATA_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Read(Read), .Write(Write),
    .R_Address(R_Address), .W_Address(W_Address), .W_Data(W_Data),
    .Busy(Busy), .R_Data(R_Data), .R_Valid(R_Valid), .W_Done(W_Done),
    .Err(Err), .Overrun(Overrun),
`ifdef FB_SRAM_ACCESS_COUNT_EN
    .Rd_Count(Rd_Count), .Wr_Count(Wr_Count),
`endif
    .SRAM_Addr(SRAM_Addr), .SRAM_DQ_Out(SRAM_DQ_Out), .SRAM_DQ_In(SRAM_DQ_In),
    .SRAM_DQ_OE(SRAM_DQ_OE), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N),
    .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // SRAM model: preloaded on the first edge, captures writes while CE_N and WE_N are low.
  logic [15:0] mem [0:524287];
  bit          pre = 1'b0;
  always @(posedge Clk) begin
    if (!pre) begin
      mem[19'h00010] <= 16'hBEEF;
      mem[19'h00005] <= 16'h5555;
      mem[19'h00020] <= 16'h2020;
      mem[19'h00031] <= 16'h0BAD;
      pre            <= 1'b1;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      mem[SRAM_Addr[18:0]] <= SRAM_DQ_Out;
    end
  end
  always_comb SRAM_DQ_In = (!SRAM_CE_N && !SRAM_OE_N) ? mem[SRAM_Addr[18:0]] : 16'h0000;

  typedef struct {
    int          kind;   // 0 read, 1 write done, 2 error
    logic [15:0] data;
    int          at;
  } exp_t;
  exp_t sb[$];
  int   nvec = 0, nfail = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [15:0] data, input int at);
    exp_t e;
    e.kind = kind; e.data = data; e.at = at;
    sb.push_back(e);
  endtask

  task automatic got(input int kind, input logic [15:0] d);
    exp_t e;
    nvec++;
    if (sb.size() == 0) begin
      nfail++;
      $display("FAIL unexpected_strobe: got kind %0d data %h at cycle %0d, want none", kind, d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.data !== d || e.at != cyc) begin
        nfail++;
        $display("FAIL scoreboard: got kind %0d data %h cycle %0d, want kind %0d data %h cycle %0d",
                 kind, d, cyc, e.kind, e.data, e.at);
      end
    end
  endtask

  always @(negedge Clk) begin
    if (mon_en) begin
      if (R_Valid) got(0, R_Data);
      if (W_Done)  got(1, 16'h0);
      if (Err)     got(2, 16'h0);
      chk("we_oe_overlap", {31'b0, !SRAM_WE_N && !SRAM_OE_N}, 32'd0);
      chk("dq_oe_during_read", {31'b0, SRAM_DQ_OE && !SRAM_OE_N}, 32'd0);
    end
  end

  initial begin
    int a, nlow;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk("rst_busy", Busy, 0);
    chk("rst_ctrl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_DQ_OE}, 4'b1110);
    chk("rst_addr", SRAM_Addr, 0);
    chk("rst_rdata", R_Data, 0);
    chk("rst_strobes", {R_Valid, W_Done, Err, Overrun}, 0);
    mon_en = 1'b1;

    // Single read
    a = cyc + 1; Read = 1'b1; R_Address = 20'h00010;
    expect_ev(0, 16'hBEEF, a + 1 + WC);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk); Read = 1'b0;
      chk("t1_busy", Busy, i < 3);
      chk("t1_oe_n", SRAM_OE_N, i >= 3);
      chk("t1_we_n", SRAM_WE_N, 1);
    end

    // Single write at the last legal address
    a = cyc + 1; Write = 1'b1; W_Address = 20'd307199; W_Data = 16'h1234;
    expect_ev(1, 16'h0, a + 2 + WC);
    nlow = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk); Write = 1'b0;
      if (!SRAM_WE_N) nlow++;
      chk("t2_dq_oe", SRAM_DQ_OE, i < 4);
      chk("t2_we_n", SRAM_WE_N, !(i == 1 || i == 2));
    end
    chk("t2_we_low_cycles", nlow, 2);
    chk("t2_mem", mem[307199], 16'h1234);

    // Read and Write in the same IDLE cycle
    a = cyc + 1; Read = 1'b1; R_Address = 20'd5; Write = 1'b1; W_Address = 20'd6; W_Data = 16'hA6A6;
    expect_ev(0, 16'h5555, a + 3);
    expect_ev(1, 16'h0, a + 8);
    for (int i = 0; i < 9; i++) begin
      @(negedge Clk); Read = 1'b0; Write = 1'b0;
      chk("t3_busy", Busy, i < 8);
      chk("t3_ce_n", SRAM_CE_N, i == 3 || i == 8);
    end
    chk("t3_overrun", Overrun, 0);
    chk("t3_mem", mem[6], 16'hA6A6);

    // Two writes during an in-flight read
    a = cyc + 1; Read = 1'b1; R_Address = 20'h00020;
    expect_ev(0, 16'h2020, a + 3);
    @(negedge Clk); Read = 1'b0; Write = 1'b1; W_Address = 20'h00030; W_Data = 16'h3333;
    @(negedge Clk); W_Address = 20'h00031; W_Data = 16'h4444;
    chk("t4_overrun_pre", Overrun, 0);
    expect_ev(1, 16'h0, a + 8);
    @(negedge Clk); Write = 1'b0;
    chk("t4_overrun", Overrun, 1);
    repeat (8) @(negedge Clk);
    chk("t4_mem_kept", mem[19'h30], 16'h3333);
    chk("t4_mem_dropped", mem[19'h31], 16'h0BAD);
    chk("t4_busy", Busy, 0);

    // Out-of-range read
    a = cyc + 1; Read = 1'b1; R_Address = 20'd307200;
    expect_ev(2, 16'h0, a);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); Read = 1'b0;
      chk("t5_ce_n", SRAM_CE_N, 1);
      chk("t5_busy", Busy, 0);
    end
`ifdef FB_SRAM_ACCESS_COUNT_EN
    chk("cnt_rd", Rd_Count, 3);
    chk("cnt_wr", Wr_Count, 3);
`endif

    // Reset during the write pulse
    Write = 1'b1; W_Address = 20'h00040; W_Data = 16'h7777;
    @(negedge Clk); Write = 1'b0;
    @(negedge Clk);
    chk("t6_in_pulse", SRAM_WE_N, 0);
    Reset = 1'b1;
    @(negedge Clk);
    chk("t6_ctrl", {SRAM_CE_N, SRAM_WE_N, SRAM_DQ_OE}, 3'b110);
    chk("t6_busy", Busy, 0);
    chk("t6_overrun", Overrun, 0);
`ifdef FB_SRAM_ACCESS_COUNT_EN
    chk("t6_cnt", {Rd_Count, Wr_Count}, 0);
`endif
    Reset = 1'b0;
    repeat (6) @(negedge Clk);
    chk("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
